// File: rtl/uart_copi_tx_fifo.sv
// Parametrised UART transmitter for the COPI link: small input FIFO with a
// valid/ready handshake feeding a start/data/parity/stop serialiser.
module uart_copi_tx_fifo #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          ser_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [2:0]                    state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST   = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                cur_state, nxt_state;
   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  push, pop, load, fifo_empty;
   logic [DATA_BITS-1:0]  head;
   logic [DATA_BITS-1:0]  shift_reg, shift_nxt;
   logic                  parity_reg, parity_nxt;
   logic [PW-1:0]         period_cnt, period_nxt;
   logic [BW-1:0]         bit_cnt, bit_nxt;
   logic                  line_level;

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~^d : ^d;
   endfunction

   assign fifo_empty = (count == '0);
   assign tx_ready   = (count < FULL_COUNT);
   assign push       = tx_valid && tx_ready;
   assign overflow   = tx_valid && !tx_ready;
   assign head       = mem[rd_ptr];
   assign fifo_count = count;
   assign busy       = (cur_state != ST_IDLE) || !fifo_empty;
   assign state      = cur_state;

   // NOTE: the storage array has no reset; only the pointers and count say what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state  <= ST_IDLE;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
         period_cnt <= '0;
         bit_cnt    <= '0;
         ser_data   <= 1'b1;
      end else begin
         cur_state  <= nxt_state;
         shift_reg  <= shift_nxt;
         parity_reg <= parity_nxt;
         period_cnt <= period_nxt;
         bit_cnt    <= bit_nxt;
         ser_data   <= line_level;
      end
   end

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      nxt_state  = cur_state;
      shift_nxt  = shift_reg;
      parity_nxt = parity_reg;
      period_nxt = period_cnt;
      bit_nxt    = bit_cnt;
      load       = 1'b0;
      pop        = 1'b0;

      if (cur_state == ST_IDLE) begin
         load = !fifo_empty;
      end else if (period_cnt != PERIOD_LAST) begin
         period_nxt = period_cnt + PW'(1);
      end else begin
         period_nxt = '0;
         case (cur_state)
            ST_START: begin
               nxt_state = ST_DATA;
               bit_nxt   = '0;
            end
            ST_DATA: begin
               shift_nxt = shift_reg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_nxt   = '0;
                  nxt_state = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_nxt = bit_cnt + BW'(1);
               end
            end
            ST_PARITY: begin
               nxt_state = ST_STOP;
               bit_nxt   = '0;
            end
            ST_STOP: begin
               // Popping on the last stop cycle keeps back-to-back frames gapless.
               if (bit_cnt == STOP_LAST) begin
                  load      = !fifo_empty;
                  nxt_state = ST_IDLE;
               end else begin
                  bit_nxt = bit_cnt + BW'(1);
               end
            end
            default: nxt_state = ST_IDLE;
         endcase
      end

      if (load) begin
         pop        = 1'b1;
         shift_nxt  = head;
         parity_nxt = calc_parity(head);
         period_nxt = '0;
         bit_nxt    = '0;
         nxt_state  = ST_START;
      end
   end

   always_comb begin
      case (cur_state)
         ST_START:  line_level = 1'b0;
         ST_DATA:   line_level = shift_reg[0];
         ST_PARITY: line_level = parity_reg;
         default:   line_level = 1'b1;
      endcase
   end

endmodule
